hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard controller for the 5-stage core. Drives the hold/flush controls of
//   the PC, the IF/ID register and the ID/EX register.
//   - Detects load-use hazards between the EX-stage load and the ID-stage consumer.
//   - Sequences instruction-memory wait cycles and branch redirects resolved in ID.
//   - Keeps stall statistics and an I-fetch timeout flag for debug.
// PARAMETERS
//   TIMEOUT   256  consecutive IMISS cycles before imemTimeout is set (>=1)
//   CNT_W     16   width of stallCount
// PORTS
//   clk          in   1      core clock; all state updates on posedge
//   reset        in   1      synchronous, active-high
//   idRs         in   5      rs field of instruction in ID
//   idRt         in   5      rt field of instruction in ID
//   idUsesRt     in   1      1: ID instruction reads rt as a source (R-type, beq/bne, sw)
//   exMemRead    in   1      1: instruction in EX is a load
//   exRt         in   5      destination register of the EX load
//   branchTaken  in   1      branch/jump in ID resolved taken this cycle
//   imemReady    in   1      instruction memory returns valid data this cycle
//   pcStall      out  1      1: PC holds its value
//   ifIdStall    out  1      1: IF/ID holds (drives IF_ID stall)
//   ifIdFlush    out  1      1: IF/ID loads a bubble (32'b0 instruction)
//   idExBubble   out  1      1: ID/EX control fields are zeroed
//   stallCount   out  CNT_W  saturating count of cycles with pcStall=1
//   imemTimeout  out  1      sticky; set when an IMISS lasts TIMEOUT cycles
// BEHAVIOUR
//   State register {RUN, LU, IMISS}. Reset -> RUN, stallCount=0, imemTimeout=0.
//   While reset=1 all four control outputs are 0.
//   loadUse = exMemRead && exRt!=0 && (exRt==idRs || (idUsesRt && exRt==idRt)).
//   Control outputs are combinational from the registered state and the current inputs.
//   The state, stallCount and imemTimeout update on posedge clk.
//   Priority within a cycle: loadUse > branchTaken > !imemReady.
//   RUN:
//     - loadUse: pcStall=1, ifIdStall=1, idExBubble=1; branchTaken ignored; next LU.
//     - elif branchTaken: pcStall=0 (PC loads target), ifIdFlush=1; next RUN.
//       An imemReady=0 in the same cycle is ignored (wrong-path fetch discarded).
//     - elif !imemReady: pcStall=1, ifIdFlush=1; next IMISS; miss counter := 1.
//     - else all outputs 0; stay RUN.
//   LU (exactly one cycle, the load is now in MEM):
//     - loadUse is masked.
//     - branchTaken / imemReady are evaluated as in RUN.
//     - The next state is RUN, or IMISS on a miss.
//   IMISS:
//     - ID holds a bubble, so branchTaken and loadUse cannot be legally asserted here.
//     - imemReady=0: pcStall=1, ifIdFlush=1; miss counter +1 (saturates at TIMEOUT).
//       When the counter reaches TIMEOUT: imemTimeout := 1.
//     - imemReady=1: outputs 0, so IF/ID captures the fetched word; next RUN.
//   Output rules:
//     - ifIdStall and ifIdFlush are never 1 in the same cycle.
//     - idExBubble=1 only with ifIdStall=1.
//   stallCount: +1 on every cycle with pcStall=1 and reset=0; saturates at 2^CNT_W-1, no wrap.
//   imemTimeout: cleared only by reset.
//   Reset mid-IMISS or mid-LU: state -> RUN next edge; no pending redirect is retained.
// TESTING
//   1. lw $2 in EX (exMemRead=1, exRt=2), ID idRs=2 -> 1 cycle:
//      pcStall=ifIdStall=idExBubble=1; next cycle outputs 0; stallCount=1.
//   2. exRt=0 with exMemRead=1, idRs=0 -> no stall. exRt=5, idRt=5, idUsesRt=0 -> no stall.
//   3. branchTaken=1 with imemReady=0 in RUN -> ifIdFlush=1, pcStall=0; state stays RUN.
//   4. imemReady low 3 cycles, then high -> pcStall=ifIdFlush=1 for 3 cycles, 0 on the 4th;
//      stallCount=3.
//   5. TIMEOUT=4, imemReady held low -> imemTimeout rises after the 4th IMISS cycle and stays
//      1 after imemReady=1; reset clears it.
//   6. Assert reset during IMISS -> next cycle state RUN, all outputs 0, stallCount=0.
//      Hold stalls 2^CNT_W+2 cycles (CNT_W=4) -> stallCount=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects and I-fetch wait
// sequencing for the 5-stage core, plus stall statistics and a sticky fetch-timeout flag.
module hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             branchTaken,
  input  logic             imemReady,
  output logic             pcStall,
  output logic             ifIdStall,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic [CNT_W-1:0] stallCount,
  output logic             imemTimeout,
  output logic [1:0]       dbg_state_o
);

  localparam int MW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    IMISS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             load_use;

  assign load_use = exMemRead && (exRt != 5'd0) &&
                    ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

  always_comb begin
    pcStall    = 1'b0;
    ifIdStall  = 1'b0;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    state_d    = state_q;
    miss_d     = miss_q;
    if (!reset) begin
      case (state_q)
        RUN, LU: begin
          // LU lasts one cycle: the load has moved to MEM, so its hazard is masked.
          if (load_use && (state_q == RUN)) begin
            pcStall    = 1'b1;
            ifIdStall  = 1'b1;
            idExBubble = 1'b1;
            state_d    = LU;
          end else if (branchTaken) begin
            ifIdFlush = 1'b1;
            state_d   = RUN;
          end else if (!imemReady) begin
            pcStall   = 1'b1;
            ifIdFlush = 1'b1;
            state_d   = IMISS;
            miss_d    = MW'(1);
          end else begin
            state_d = RUN;
          end
        end
        IMISS: begin
          if (!imemReady) begin
            pcStall   = 1'b1;
            ifIdFlush = 1'b1;
            if (miss_q != MW'(TIMEOUT)) miss_d = miss_q + MW'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // The entry cycle of a miss counts as its first cycle.
  assign timeout_d = timeout_q || ((state_d == IMISS) && (miss_d == MW'(TIMEOUT)));
  assign cnt_d     = (pcStall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      miss_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stallCount  = cnt_q;
  assign imemTimeout = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized checks of hazard_ctrl against a behavioural model of the
// pipeline rules (mode: 0 running, 1 load just stalled, 2 waiting on instruction memory).
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       idRs, idRt, exRt;
  logic             idUsesRt, exMemRead, branchTaken, imemReady;
  logic             pcStall, ifIdStall, ifIdFlush, idExBubble, imemTimeout;
  logic [CNT_W-1:0] stallCount;
  logic [1:0]       dbg_state;

  int passed = 0;
  int total  = 0;

  // reference model state
  int m_mode = 0;
  int m_miss = 0;
  int m_cnt  = 0;
  bit m_to   = 0;
  bit e_pc, e_st, e_fl, e_bub, e_lu;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken), .imemReady(imemReady),
    .pcStall(pcStall), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush), .idExBubble(idExBubble),
    .stallCount(stallCount), .imemTimeout(imemTimeout), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_comb();
    e_pc = 0; e_st = 0; e_fl = 0; e_bub = 0; e_lu = 0;
    if (reset) return;
    if (m_mode == 2) begin
      if (!imemReady) begin e_pc = 1; e_fl = 1; end
      return;
    end
    e_lu = (m_mode == 0) && exMemRead && (exRt != 0) &&
           ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    if (e_lu) begin e_pc = 1; e_st = 1; e_bub = 1; end
    else if (branchTaken) e_fl = 1;
    else if (!imemReady) begin e_pc = 1; e_fl = 1; end
  endtask

  task automatic model_seq();
    if (reset) begin
      m_mode = 0; m_miss = 0; m_cnt = 0; m_to = 0;
      return;
    end
    if (e_pc && m_cnt < CMAX) m_cnt++;
    if (m_mode == 2) begin
      if (imemReady) begin m_mode = 0; m_miss = 0; end
      else if (m_miss < TO) m_miss++;
    end else if (e_lu) m_mode = 1;
    else if (branchTaken) m_mode = 0;
    else if (!imemReady) begin m_mode = 2; m_miss = 1; end
    else m_mode = 0;
    if (m_mode == 2 && m_miss >= TO) m_to = 1;
  endtask

  // Inputs are driven just after a posedge; outputs sampled mid-cycle and after the edge.
  task automatic cycle();
    #2;
    model_comb();
    chk("pcStall", pcStall, e_pc);
    chk("ifIdStall", ifIdStall, e_st);
    chk("ifIdFlush", ifIdFlush, e_fl);
    chk("idExBubble", idExBubble, e_bub);
    @(posedge clk);
    #1;
    model_seq();
    chk("stallCount", stallCount, m_cnt);
    chk("imemTimeout", imemTimeout, m_to);
    chk("state", dbg_state, m_mode);
  endtask

  task automatic idle();
    reset = 0; idRs = 5'd1; idRt = 5'd3; idUsesRt = 0; exMemRead = 0; exRt = 5'd0;
    branchTaken = 0; imemReady = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    cycle(); cycle();
    idle();

    // load-use on rs: one stall cycle then clear
    exMemRead = 1; exRt = 5'd2; idRs = 5'd2;
    cycle();
    chk("lu_count", stallCount, 1);
    cycle();
    idle(); cycle();

    // no hazard: $zero destination, and rt match without rt use
    exMemRead = 1; exRt = 5'd0; idRs = 5'd0; cycle();
    exRt = 5'd5; idRt = 5'd5; idUsesRt = 0; idRs = 5'd7; cycle();
    idUsesRt = 1; cycle();               // rt hazard now real
    idle(); cycle();

    // load-use beats a branch in the same cycle
    exMemRead = 1; exRt = 5'd4; idRs = 5'd4; branchTaken = 1; cycle();
    idle(); cycle();

    // branch with simultaneous miss: flush only, stay running
    branchTaken = 1; imemReady = 0; cycle();
    chk("br_state_run", dbg_state, 0);
    idle(); cycle();

    // three miss cycles then ready
    reset = 1; cycle(); idle();
    imemReady = 0; cycle(); cycle(); cycle();
    imemReady = 1; cycle();
    chk("miss3_count", stallCount, 3);
    chk("miss3_no_to", imemTimeout, 0);

    // timeout after the 4th miss cycle, sticky after recovery
    imemReady = 0; cycle(); cycle(); cycle();
    chk("to_pre", imemTimeout, 0);
    cycle();
    chk("to_set", imemTimeout, 1);
    imemReady = 1; cycle(); cycle();
    chk("to_sticky", imemTimeout, 1);

    // reset in the middle of a miss
    imemReady = 0; cycle();
    reset = 1; cycle();
    chk("rst_state", dbg_state, 0);
    chk("rst_count", stallCount, 0);
    chk("rst_to", imemTimeout, 0);
    idle(); cycle();

    // stallCount saturation
    imemReady = 0;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) cycle();
    chk("sat_count", stallCount, CMAX);
    imemReady = 1; cycle();

    // randomized traffic with legal inputs only
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      idRs        = 5'($urandom_range(0, 3));
      idRt        = 5'($urandom_range(0, 3));
      idUsesRt    = 1'($urandom_range(0, 1));
      exRt        = 5'($urandom_range(0, 3));
      exMemRead   = ($urandom_range(0, 2) == 0);
      branchTaken = ($urandom_range(0, 5) == 0);
      imemReady   = ($urandom_range(0, 3) != 0);
      if (m_mode == 2) begin exMemRead = 0; branchTaken = 0; end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
